// File: rtl/wr_arria10_phy_pkg.sv
// Shared types for the Arria10 WR PHY wrapper: reset supervisor state encoding
// (also exported on the status register) and the retry saturation limit.
package wr_arria10_phy_pkg;

   typedef enum logic [2:0] {
      RESET_HOLD = 3'd0,
      WAIT_TX    = 3'd1,
      WAIT_RX    = 3'd2,
      LINK_UP    = 3'd3
   } t_rst_sup_state;

   localparam int c_RETRY_MAX = 255;

endpackage

// File: rtl/wr_arria10_phy_rst_supervisor.sv
// Sequences the Arria10 transceiver reset controller: pulse its reset, wait for
// tx_ready then rx_ready, hold link_up, and restart on any fault or request.
module wr_arria10_phy_rst_supervisor
   import wr_arria10_phy_pkg::*;
#(
   parameter int RST_PULSE_CYCLES = 16,
   parameter int TX_TIMEOUT       = 1048576,
   parameter int RX_TIMEOUT       = 4194304,
   parameter int LOL_FILTER       = 256
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_reset,
   input  logic       tx_ready,
   input  logic       rx_ready,
   input  logic       rx_is_lockedtodata,
   output logic       rst_ctl_reset,
   output logic       link_up,
   output logic [2:0] state_o,
   output logic [7:0] retry_count,
   output logic       timeout_seen
);

   localparam int MAX_A = (RST_PULSE_CYCLES > TX_TIMEOUT) ? RST_PULSE_CYCLES : TX_TIMEOUT;
   localparam int MAX_B = (RX_TIMEOUT > LOL_FILTER) ? RX_TIMEOUT : LOL_FILTER;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAX_C + 1);

   localparam logic [CW-1:0] PULSE_LAST = CW'(RST_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TX_LAST    = CW'(TX_TIMEOUT - 1);
   localparam logic [CW-1:0] RX_LAST    = CW'(RX_TIMEOUT - 1);
   localparam logic [CW-1:0] LOL_LAST   = CW'(LOL_FILTER - 1);

   t_rst_sup_state state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           retry, tmo;

   assign state_o = state;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CW'(1);
      retry     = 1'b0;
      tmo       = 1'b0;
      unique case (state)
         RESET_HOLD: begin
            // a held request keeps the pulse stretched until it is released
            if (req_reset)                cnt_nxt   = '0;
            else if (cnt == PULSE_LAST)   state_nxt = WAIT_TX;
         end
         WAIT_TX: begin
            if (req_reset) begin
               state_nxt = RESET_HOLD;
               retry     = 1'b1;
            end else if (tx_ready) begin
               state_nxt = WAIT_RX;
            end else if (cnt == TX_LAST) begin
               state_nxt = RESET_HOLD;
               retry     = 1'b1;
               tmo       = 1'b1;
            end
         end
         WAIT_RX: begin
            if (req_reset || !tx_ready) begin
               state_nxt = RESET_HOLD;
               retry     = 1'b1;
            end else if (rx_ready) begin
               state_nxt = LINK_UP;
            end else if (cnt == RX_LAST) begin
               state_nxt = RESET_HOLD;
               retry     = 1'b1;
               tmo       = 1'b1;
            end
         end
         LINK_UP: begin
            // cnt is the consecutive loss-of-lock run here
            if (req_reset || !tx_ready || !rx_ready) begin
               state_nxt = RESET_HOLD;
               retry     = 1'b1;
            end else if (rx_is_lockedtodata) begin
               cnt_nxt   = '0;
            end else if (cnt == LOL_LAST) begin
               state_nxt = RESET_HOLD;
               retry     = 1'b1;
            end
         end
         default: state_nxt = RESET_HOLD;
      endcase
      if (state_nxt != state) cnt_nxt = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= RESET_HOLD;
         cnt           <= '0;
         rst_ctl_reset <= 1'b1;
         link_up       <= 1'b0;
         retry_count   <= '0;
         timeout_seen  <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         rst_ctl_reset <= (state_nxt == RESET_HOLD);
         link_up       <= (state_nxt == LINK_UP);
         if (retry && (retry_count != 8'(c_RETRY_MAX))) retry_count <= retry_count + 8'd1;
         if (tmo) timeout_seen <= 1'b1;
      end
   end

endmodule
